conv_mac_unit: RTL and testbench
================================

Name: conv_mac_unit

Overview:
- Compute stage directly downstream of the convolution address FSM.
- Consumes pixel words read from the tile buffer at the FSM's addresses. Each pixel arrives with a window-start flag, which is the FSM's comp_unit_control aligned to read data.
- Multiplies each pixel by its filter weight and accumulates over the filter window (1x1, 2x2 or 3x3).
- Pushes each completed window sum into an output FIFO. The next stage pops the FIFO with a valid/ready handshake.

Parameters:
- DATA_W, 8, signed pixel width.
- WGT_W, 8, signed weight width.
- ACC_W, 24, signed accumulator and result width. Must be at least DATA_W+WGT_W.
- FIFO_DEPTH, 4, output FIFO entries. Must be a power of 2, minimum 2.

Ports:
- clk  input  1  clock.
- res  input  1  synchronous reset, active-high.
- filter_size  input  2  filter edge length, 1..3. Sampled on each window start.
- wgt_wr_en  input  1  weight register write strobe.
- wgt_wr_idx  input  4  weight index, 0..8, row-major.
- wgt_wr_data  input  WGT_W  signed weight.
- pix_valid  input  1  pix_data is valid this cycle.
- pix_data  input  DATA_W  signed pixel.
- win_start  input  1  qualified by pix_valid: this pixel is tap 0 of a new window.
- done_in  input  1  upstream address FSM finished (level).
- res_valid  output  1  FIFO not empty.
- res_data  output  ACC_W  FIFO head value.
- res_ready  input  1  consumer accepts the head this cycle.
- busy  output  1  state is not IDLE and not DONE.
- all_done  output  1  all results produced and popped.
- protocol_err  output  1  sticky protocol error flag.
- overflow  output  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset:
  - All outputs 0. FIFO empty. Accumulator and pipeline cleared. State IDLE.
  - Weight registers are cleared to 0.
  - Reset mid-window discards the partial sum.
- Pipeline:
  - Stage 1 registers pix_data*w[tap].
  - Stage 2 adds the product into acc with signed saturation to the ACC_W range. Tap 0 loads acc with the product instead of adding.
  - Stage 3 pushes the final acc to the FIFO.
  - Latency: last-tap pixel at cycle t; res_valid rises at t+3 if the FIFO was empty and there is no backpressure.
- Taps: taps = filter_size*filter_size, latched at win_start.
  - tap_cnt increments on every accepted pixel.
  - The window is complete when tap_cnt reaches taps.
- State machine:
  - IDLE: pix_valid&win_start with filter_size!=0 -> ACCUM with tap_cnt=1. A pixel without win_start -> protocol_err, pixel ignored.
  - ACCUM: pix_valid&!win_start accumulates. On the last tap -> WAIT.
  - ACCUM, early window start: pix_valid&win_start before the last tap sets protocol_err, discards the partial sum and restarts the window with this pixel.
  - WAIT: pix_valid&win_start -> ACCUM, new window. pix_valid without win_start -> protocol_err, ignored. done_in=1 with no pix_valid -> DRAIN.
  - DRAIN: stays until the pipeline is empty and the FIFO is empty -> DONE.
  - DONE: all_done=1. Ignores pixels. Leaves only on res.
  - Any state, filter_size==0 at win_start: protocol_err, pixel ignored, state unchanged.
  - Unused encodings -> IDLE with protocol_err set.
- Weights:
  - A write takes effect the next cycle. Accepted only in IDLE or DONE.
  - Writes in other states set protocol_err and are ignored.
  - wgt_wr_idx>8 is ignored silently.
- FIFO:
  - A pop happens when res_valid&res_ready. Pop and push in the same cycle when full is legal: both occur and the count is unchanged.
  - A push when full and not popping drops the result and sets overflow.
  - res_data holds the head value while res_ready=0.
- done_in in ACCUM: ignored until WAIT, so the final window always completes.

Test Plan:
- filter_size=2, weights w0..w3=1,2,3,4; pixels 1,1,1,1 with win_start on the first and res_ready=1 -> res_data=10, res_valid exactly 3 cycles after the 4th pixel.
- filter_size=3, all weights -1, nine pixels=5 followed by a second window of nine pixels=2 -> results -45 then -18, in order, with no protocol_err.
- ACC_W=16, filter_size=3, weights -128, pixels -128 -> saturates to 32767, not wrapped.
- res_ready=0, five back-to-back 1x1 windows (weight 3, pixels 1..5), FIFO_DEPTH=4 -> overflow=1; popping then yields 3,6,9,12 and res_valid drops.
- filter_size=2; win_start asserted again on the 3rd pixel -> protocol_err=1, first window produces no result, second window (pixels 2,2,2,2, weights 1) -> 8.
- After the last result, done_in=1, and the consumer pops it -> all_done=1 one cycle after the FIFO empties; res=1 mid-DRAIN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/conv_mac_unit_if.sv
// conv_mac_unit_if
//   Stream bundle for the convolution MAC unit.
//   Pixel side : pix_valid, pix_data, win_start (producer -> MAC)
//   Result side: res_valid, res_data (MAC -> consumer), res_ready (consumer -> MAC)
//   master modport: the upstream/downstream environment around the MAC.
//   slave modport : the MAC unit itself.
interface conv_mac_unit_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) ();
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              win_start;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ready;

  modport master (
    output pix_valid, pix_data, win_start, res_ready,
    input  res_valid, res_data
  );

  modport slave (
    input  pix_valid, pix_data, win_start, res_ready,
    output res_valid, res_data
  );
endinterface

// File: rtl/conv_mac_unit.sv
// conv_mac_unit
//   Multiply-accumulate stage behind the convolution address FSM. Each
//   accepted pixel is multiplied by the weight of its tap, summed over a
//   1x1 / 2x2 / 3x3 window with signed saturation, and the window sum is
//   pushed into a small output FIFO drained by a valid/ready consumer.
// Ports:
//   clk, res           clock, synchronous active-high reset
//   filter_size        window edge length (1..3), sampled at window start
//   wgt_wr_*           weight register write port (index 0..8, row-major)
//   done_in            upstream finished (level)
//   bus (slave)        pixel stream in, result stream out
//   busy               not IDLE and not DONE
//   all_done           every result produced and consumed
//   protocol_err       sticky protocol violation flag
//   overflow           sticky, a result was dropped on a full FIFO
module conv_mac_unit #(
  parameter int DATA_W     = 8,
  parameter int WGT_W      = 8,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [1:0]              filter_size,
  input  logic                    wgt_wr_en,
  input  logic [3:0]              wgt_wr_idx,
  input  logic signed [WGT_W-1:0] wgt_wr_data,
  input  logic                    done_in,
  conv_mac_unit_if.slave          bus,
  output logic                    busy,
  output logic                    all_done,
  output logic                    protocol_err,
  output logic                    overflow
);
  localparam int PROD_W = DATA_W + WGT_W;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [3:0] tap_cnt_q, tap_cnt_d;
  logic [3:0] taps_q, taps_d;
  logic       perr_q, perr_d;
  logic       ovf_q, ovf_d;

  // Weight registers
  logic signed [WGT_W-1:0] w_q [0:8];
  logic signed [WGT_W-1:0] w_d [0:8];

  // Pipeline registers
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_first_q, s1_first_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     s2_last_q, s2_last_d;

  // Output FIFO
  logic [ACC_W-1:0] fifo_mem_q [0:FIFO_DEPTH-1];
  logic [ACC_W-1:0] fifo_mem_d [0:FIFO_DEPTH-1];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Decoded pixel events
  logic       start_ok, pix_cont, pix_fs0;
  logic [3:0] fs_taps;
  logic       wgt_hit, wgt_ok, wgt_bad;
  logic       take, take_first, take_last, new_win, perr_set;
  logic [3:0] tap_idx;
  logic       pipe_empty, fifo_empty, fifo_full, push, pop, push_ok, drop;

  assign fs_taps  = 4'({2'b00, filter_size} * {2'b00, filter_size});
  assign start_ok = bus.pix_valid && bus.win_start && (filter_size != 2'd0);
  assign pix_fs0  = bus.pix_valid && bus.win_start && (filter_size == 2'd0);
  assign pix_cont = bus.pix_valid && !bus.win_start;

  // Out-of-range indices are dropped without flagging anything.
  assign wgt_hit = wgt_wr_en && (wgt_wr_idx <= 4'd8);
  assign wgt_ok  = wgt_hit && (state_q == S_IDLE || state_q == S_DONE);
  assign wgt_bad = wgt_hit && !wgt_ok;

  assign pipe_empty = !s1_valid_q && !s2_last_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // Next state and tap sequencing
  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    taps_d     = taps_q;
    take       = 1'b0;
    take_first = 1'b0;
    take_last  = 1'b0;
    tap_idx    = 4'd0;
    new_win    = 1'b0;
    perr_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) new_win = 1'b1;
        else if (pix_cont) perr_set = 1'b1;
      end
      S_ACCUM: begin
        if (start_ok) begin
          // Early restart: tap 0 reloads acc, so the partial sum is lost.
          new_win  = 1'b1;
          perr_set = 1'b1;
        end else if (pix_cont) begin
          take      = 1'b1;
          tap_idx   = tap_cnt_q;
          take_last = (4'(tap_cnt_q + 4'd1) == taps_q);
          tap_cnt_d = 4'(tap_cnt_q + 4'd1);
          if (take_last) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (start_ok) new_win = 1'b1;
        else if (pix_cont) perr_set = 1'b1;
        else if (done_in && !bus.pix_valid) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_empty && fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d  = S_IDLE;
        perr_set = 1'b1;
      end
    endcase
    if (new_win) begin
      take       = 1'b1;
      take_first = 1'b1;
      tap_idx    = 4'd0;
      tap_cnt_d  = 4'd1;
      taps_d     = fs_taps;
      take_last  = (fs_taps == 4'd1);
      state_d    = take_last ? S_WAIT : S_ACCUM;
    end
    if (pix_fs0 || wgt_bad) perr_set = 1'b1;
  end

  // Weight update
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_d[i] = w_q[i];
      if (wgt_ok && (wgt_wr_idx == 4'(i))) w_d[i] = wgt_wr_data;
    end
  end

  // Stage 1: product of pixel and tap weight
  logic signed [WGT_W-1:0]  w_sel;
  logic signed [PROD_W-1:0] pix_ext, wgt_ext;
  assign w_sel   = (tap_idx <= 4'd8) ? w_q[tap_idx] : '0;
  assign pix_ext = PROD_W'($signed(bus.pix_data));
  assign wgt_ext = PROD_W'(w_sel);

  always_comb begin
    s1_valid_d = take;
    s1_first_d = take_first;
    s1_last_d  = take_last;
    prod_d     = take ? (pix_ext * wgt_ext) : prod_q;
  end

  // Stage 2: saturating accumulate; one extra bit catches the overflow.
  logic signed [ACC_W-1:0] prod_acc;
  logic [ACC_W:0]          sum_wide;
  assign prod_acc = ACC_W'(prod_q);
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_acc[ACC_W-1], prod_acc};

  always_comb begin
    acc_d     = acc_q;
    s2_last_d = s1_valid_q && s1_last_q;
    if (s1_valid_q) begin
      if (s1_first_q) begin
        acc_d = prod_acc;
      end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
        acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum_wide[ACC_W-1:0];
      end
    end
  end

  // Stage 3: FIFO. A full FIFO still takes a push when the head leaves.
  assign push    = s2_last_q;
  assign pop     = bus.res_valid && bus.res_ready;
  assign push_ok = push && (!fifo_full || pop);
  assign drop    = push && fifo_full && !pop;

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_d[i] = fifo_mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = acc_q;
      wr_ptr_d = AW'(wr_ptr_q + 1'b1);
    end
    if (pop) rd_ptr_d = AW'(rd_ptr_q + 1'b1);
    if (push_ok && !pop) count_d = CW'(count_q + 1'b1);
    else if (!push_ok && pop) count_d = CW'(count_q - 1'b1);
  end

  always_comb begin
    perr_d = perr_q | perr_set;
    ovf_d  = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      tap_cnt_q  <= '0;
      taps_q     <= '0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      s2_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      tap_cnt_q  <= tap_cnt_d;
      taps_q     <= taps_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      s2_last_q  <= s2_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < 9; i++) w_q[i] <= w_d[i];
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= fifo_mem_d[i];
    end
  end

  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = fifo_mem_q[rd_ptr_q];
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign all_done      = (state_q == S_DONE);
  assign protocol_err  = perr_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_conv_mac_unit.sv
// Scoreboard bench: two MAC instances (24-bit and 16-bit accumulators) share
// one stimulus stream; each has its own expected-result queue and monitor.
module tb_conv_mac_unit;
  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic [1:0]       filter_size = 2'd1;
  logic             wgt_wr_en = 1'b0;
  logic [3:0]       wgt_wr_idx = 4'd0;
  logic signed [7:0] wgt_wr_data = 8'sd0;
  logic             done_in = 1'b0;
  logic             pix_valid = 1'b0;
  logic signed [7:0] pix_data = 8'sd0;
  logic             win_start = 1'b0;
  logic             res_ready = 1'b0;

  logic busy, all_done, protocol_err, overflow;
  logic busy16, all_done16, perr16, ovf16;

  int errors = 0;
  int checks = 0;
  int q24[$];
  int q16[$];

  always #5 clk = ~clk;

  conv_mac_unit_if #(.DATA_W(8), .ACC_W(24)) ifc ();
  conv_mac_unit_if #(.DATA_W(8), .ACC_W(16)) ifc16 ();

  assign ifc.pix_valid   = pix_valid;
  assign ifc.pix_data    = pix_data;
  assign ifc.win_start   = win_start;
  assign ifc.res_ready   = res_ready;
  assign ifc16.pix_valid = pix_valid;
  assign ifc16.pix_data  = pix_data;
  assign ifc16.win_start = win_start;
  assign ifc16.res_ready = res_ready;

  conv_mac_unit #(.DATA_W(8), .WGT_W(8), .ACC_W(24), .FIFO_DEPTH(4)) dut (
    .clk(clk), .res(res), .filter_size(filter_size), .wgt_wr_en(wgt_wr_en),
    .wgt_wr_idx(wgt_wr_idx), .wgt_wr_data(wgt_wr_data), .done_in(done_in),
    .bus(ifc), .busy(busy), .all_done(all_done), .protocol_err(protocol_err),
    .overflow(overflow)
  );

  conv_mac_unit #(.DATA_W(8), .WGT_W(8), .ACC_W(16), .FIFO_DEPTH(4)) dut16 (
    .clk(clk), .res(res), .filter_size(filter_size), .wgt_wr_en(wgt_wr_en),
    .wgt_wr_idx(wgt_wr_idx), .wgt_wr_data(wgt_wr_data), .done_in(done_in),
    .bus(ifc16), .busy(busy16), .all_done(all_done16), .protocol_err(perr16),
    .overflow(ovf16)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int idx, input int val);
    wgt_wr_en   = 1'b1;
    wgt_wr_idx  = 4'(idx);
    wgt_wr_data = 8'(val);
    step();
    wgt_wr_en   = 1'b0;
  endtask

  task automatic pix(input int d, input bit ws);
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    win_start = ws;
    step();
    pix_valid = 1'b0;
    win_start = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 40 && (q24.size() != 0 || q16.size() != 0); i++) step();
    step();
  endtask

  task automatic do_reset(input bit discard);
    if (!discard) chk("sb_empty_before_reset", q24.size() + q16.size(), 0);
    q24.delete();
    q16.delete();
    res = 1'b1;
    done_in = 1'b0;
    step();
    step();
    res = 1'b0;
  endtask

  // Monitors: pop the expected value on every accepted result.
  always @(negedge clk) begin
    if (!res && ifc.res_valid && ifc.res_ready) begin
      if (q24.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result24: got %0d, expected none", $signed(ifc.res_data));
      end else begin
        int e;
        e = q24.pop_front();
        $display("txn acc24 result %0d (expected %0d)", $signed(ifc.res_data), e);
        chk("result24", int'($signed(ifc.res_data)), e);
      end
    end
  end

  always @(negedge clk) begin
    if (!res && ifc16.res_valid && ifc16.res_ready) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result16: got %0d, expected none", $signed(ifc16.res_data));
      end else begin
        int e;
        e = q16.pop_front();
        $display("txn acc16 result %0d (expected %0d)", $signed(ifc16.res_data), e);
        chk("result16", int'($signed(ifc16.res_data)), e);
      end
    end
  end

  initial begin
    step();
    step();
    res = 1'b0;
    chk("rst_res_valid", ifc.res_valid, 0);
    chk("rst_res_data", ifc.res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_overflow", overflow, 0);

    // 2x2 window, weights 1..4, all-ones pixels -> 10 with 3-cycle latency
    filter_size = 2'd2;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr_w(i, i + 1);
    q24.push_back(10);
    q16.push_back(10);
    pix(1, 1); pix(1, 0); pix(1, 0); pix(1, 0);
    chk("t1_busy", busy, 1);
    chk("t1_valid_t1", ifc.res_valid, 0);
    step();
    chk("t1_valid_t2", ifc.res_valid, 0);
    step();
    chk("t1_valid_t3", ifc.res_valid, 1);
    drain_wait();

    // Two back-to-back 3x3 windows with weights -1
    do_reset(0);
    filter_size = 2'd3;
    for (int i = 0; i < 9; i++) wr_w(i, -1);
    q24.push_back(-45); q24.push_back(-18);
    q16.push_back(-45); q16.push_back(-18);
    for (int i = 0; i < 9; i++) pix(5, i == 0);
    for (int i = 0; i < 9; i++) pix(2, i == 0);
    drain_wait();
    chk("t2_protocol_err", protocol_err, 0);

    // Saturation: 9 * 16384 overflows only the 16-bit accumulator
    do_reset(0);
    filter_size = 2'd3;
    for (int i = 0; i < 9; i++) wr_w(i, -128);
    q24.push_back(147456);
    q16.push_back(32767);
    for (int i = 0; i < 9; i++) pix(-128, i == 0);
    drain_wait();

    // Backpressure: five 1x1 results into a 4-deep FIFO
    do_reset(0);
    res_ready = 1'b0;
    filter_size = 2'd1;
    wr_w(0, 3);
    for (int v = 1; v <= 4; v++) begin
      q24.push_back(3 * v);
      q16.push_back(3 * v);
    end
    for (int v = 1; v <= 5; v++) pix(v, 1);
    repeat (5) step();
    chk("t4_overflow", overflow, 1);
    chk("t4_res_valid_full", ifc.res_valid, 1);
    chk("t4_head_held", int'($signed(ifc.res_data)), 3);
    chk("t4_protocol_err", protocol_err, 0);
    res_ready = 1'b1;
    drain_wait();
    chk("t4_res_valid_empty", ifc.res_valid, 0);

    // Early window restart on the third pixel
    do_reset(0);
    filter_size = 2'd2;
    for (int i = 0; i < 4; i++) wr_w(i, 1);
    q24.push_back(8);
    q16.push_back(8);
    pix(7, 1); pix(7, 0);
    pix(2, 1); pix(2, 0); pix(2, 0); pix(2, 0);
    drain_wait();
    chk("t5_protocol_err", protocol_err, 1);

    // DRAIN -> DONE once the last result is popped
    do_reset(0);
    filter_size = 2'd1;
    res_ready = 1'b0;
    wr_w(0, 5);
    q24.push_back(10);
    q16.push_back(10);
    pix(2, 1);
    repeat (4) step();
    chk("t6_res_valid", ifc.res_valid, 1);
    done_in = 1'b1;
    step();
    step();
    chk("t6_drain_busy", busy, 1);
    chk("t6_drain_not_done", all_done, 0);
    res_ready = 1'b1;
    step();
    chk("t6_fifo_empty", ifc.res_valid, 0);
    chk("t6_not_done_yet", all_done, 0);
    step();
    chk("t6_all_done", all_done, 1);
    chk("t6_idle_busy", busy, 0);
    pix(3, 1);
    repeat (4) step();
    chk("t6_done_ignores_pix", ifc.res_valid, 0);
    chk("t6_done_stays", all_done, 1);

    // Reset in the middle of DRAIN with sticky flags set
    do_reset(0);
    filter_size = 2'd1;
    res_ready = 1'b0;
    wr_w(0, 5);
    q24.push_back(10);
    q16.push_back(10);
    pix(2, 1);
    repeat (4) step();
    pix(1, 0);
    done_in = 1'b1;
    step();
    step();
    chk("t7_drain_busy", busy, 1);
    chk("t7_perr_set", protocol_err, 1);
    res = 1'b1;
    step();
    chk("t7_res_valid", ifc.res_valid, 0);
    chk("t7_res_data", ifc.res_data, 0);
    chk("t7_busy", busy, 0);
    chk("t7_all_done", all_done, 0);
    chk("t7_protocol_err", protocol_err, 0);
    chk("t7_overflow", overflow, 0);
    do_reset(1);

    drain_wait();
    chk("sb_empty_final", q24.size() + q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
